// File: rtl/ec_fpn_addsub_resp_pkg.sv
// Shared definitions for the chunked mod-P add/sub responder.
//   - Default field / chunk widths and default modulus.
//   - Common ctl width, shared with the EC point blocks.
//   - Helpers: chunk count, counter width, and slicing P into chunk k.
//   - FSM state encoding for the responder.
package ec_fpn_addsub_resp_pkg;

    localparam int          EC_CTL_BITS = 8;
    localparam int          DEF_N       = 32;
    localparam int          DEF_W       = 8;
    localparam logic [31:0] DEF_P       = 32'hFFFF_FFFB;

    // Widest field element the slicing helper can handle.
    localparam int FE_MAX_BITS = 1024;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,  // accepting operand beats
        ST_FILL    = 2'd1,  // early eop: finishing missing chunks as zero
        ST_EMIT    = 2'd2   // returning result beats
    } resp_state_e;

    function automatic int div_of(input int n, input int w);
        return n / w;
    endfunction

    function automatic int cnt_bits(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

    // Chunk k (LSB first) of a value, w bits wide, returned zero-extended.
    function automatic logic [FE_MAX_BITS-1:0] p_chunk(input logic [FE_MAX_BITS-1:0] p,
                                                       input int w, input int k);
        return (p >> (k * w)) & ((FE_MAX_BITS'(1) << w) - FE_MAX_BITS'(1));
    endfunction

endpackage

// File: rtl/ec_fpn_addsub_resp_if.sv
// Stream interface used between the EC point blocks and the field arithmetic.
//   dat/ctl  payload and opaque routing tag
//   val/rdy  handshake, a beat moves when both are high on a clock edge
//   sop/eop  packet framing, err flags a damaged packet
// master/source drive the payload, slave/sink drive rdy.
interface ec_fpn_addsub_resp_if #(
    parameter int DAT_BITS = 8,
    parameter int CTL_BITS = 8
);
    logic [DAT_BITS-1:0] dat;
    logic [CTL_BITS-1:0] ctl;
    logic                val;
    logic                rdy;
    logic                sop;
    logic                eop;
    logic                err;

    modport master (output dat, ctl, val, sop, eop, err, input rdy);
    modport slave  (input dat, ctl, val, sop, eop, err, output rdy);
    modport source (output dat, ctl, val, sop, eop, err, input rdy);
    modport sink   (input dat, ctl, val, sop, eop, err, output rdy);
endinterface

// File: rtl/ec_fpn_addsub_resp_chunk.sv
// One W-bit chunk of a multi-precision add or subtract.
//   x, y   operand chunks
//   cin    carry in (ADD) or borrow in (SUB)
//   res    result chunk
//   cout   carry out (ADD) or borrow out (SUB)
module ec_fpn_addsub_resp_chunk #(
    parameter int W   = 8,
    parameter bit SUB = 1'b0
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         cin,
    output logic [W-1:0] res,
    output logic         cout
);
    logic [W:0] full;

    // Working one bit wider: for subtraction the top bit is set exactly
    // when the result went negative, i.e. it is the borrow.
    generate
        if (SUB) begin : g_sub
            assign full = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, cin};
        end else begin : g_add
            assign full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, cin};
        end
    endgenerate

    assign res  = full[W-1:0];
    assign cout = full[W];
endmodule

// File: rtl/ec_fpn_addsub_resp.sv
// Responder for the chunked mod-P add/sub stream.
//   i_clk, i_rst  clock, asynchronous active-high reset
//   i_if          operand beats: dat[W-1:0] = a chunk, dat[2W-1:W] = b chunk,
//                 LSB chunk first, DIV beats per operation
//   o_if          result beats: dat = result chunk, ctl echoed from input sop,
//                 err set on the eop beat of a malformed packet
// Both the raw result (a+b or a-b) and the P-corrected one are computed a
// chunk per beat and buffered; the final carry/borrow picks which buffer is
// returned.
module ec_fpn_addsub_resp
    import ec_fpn_addsub_resp_pkg::*;
#(
    parameter type     FE_TYPE       = logic [DEF_N-1:0],
    parameter type     FE_TYPE_ARITH = logic [DEF_W-1:0],
    parameter FE_TYPE  P             = FE_TYPE'(DEF_P),
    parameter bit      SUB           = 1'b0,
    parameter int      CTL_BITS      = EC_CTL_BITS
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    ec_fpn_addsub_resp_if.slave  i_if,
    ec_fpn_addsub_resp_if.master o_if
);
    localparam int N     = $bits(FE_TYPE);
    localparam int W     = $bits(FE_TYPE_ARITH);
    localparam int DIV   = div_of(N, W);
    localparam int CNT_W = cnt_bits(DIV);

    localparam logic [CNT_W-1:0]       LAST_IDX = CNT_W'(DIV - 1);
    localparam logic [FE_MAX_BITS-1:0] P_WIDE   = FE_MAX_BITS'(P);

    // ---------------- state ----------------
    resp_state_e         state_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic                c_main_reg;
    logic                c_corr_reg;
    logic                err_reg;
    logic                sel_reg;
    logic                rdy_reg;
    logic [CTL_BITS-1:0] ctl_reg;

    logic                o_val_reg;
    logic                o_sop_reg;
    logic                o_eop_reg;
    logic                o_err_reg;
    logic [W-1:0]        o_dat_reg;
    logic [CTL_BITS-1:0] o_ctl_reg;

    logic [W-1:0] buf_main [DIV];
    logic [W-1:0] buf_corr [DIV];

    // ---------------- P chunks ----------------
    logic [W-1:0] p_chunks [DIV];

    generate
        for (genvar gi = 0; gi < DIV; gi++) begin : g_pchunk
            assign p_chunks[gi] = W'(p_chunk(P_WIDE, W, gi));
        end
    endgenerate

    // ---------------- datapath ----------------
    logic             in_fire;
    logic             dp_fire;
    logic [CNT_W-1:0] idx;
    logic [CNT_W-1:0] idx_inc;
    logic [CNT_W-1:0] beat_inc;
    logic [W-1:0]     op_a;
    logic [W-1:0]     op_b;
    logic             cin_main;
    logic             cin_corr;
    logic             is_last;
    logic             beat_err;
    logic             to_emit;

    logic [W-1:0]     r_main;
    logic [W-1:0]     r_corr;
    logic             cout_main;
    logic             cout_corr;
    logic             sel_next;
    logic [W-1:0]     first_dat;
    logic [W-1:0]     rd_dat;

    always_comb begin
        in_fire  = (state_reg == ST_COLLECT) && rdy_reg && i_if.val;
        dp_fire  = in_fire || (state_reg == ST_FILL);
        idx      = cnt_reg;
        op_a     = '0;
        op_b     = '0;
        cin_main = 1'b0;
        cin_corr = 1'b0;
        if (in_fire) begin
            op_a = i_if.dat[W-1:0];
            op_b = i_if.dat[2*W-1:W];
            // A sop always (re)starts the packet at chunk 0.
            if (i_if.sop) begin
                idx = '0;
            end
        end
        // Chunk 0 starts a fresh carry chain.
        if (idx != '0) begin
            cin_main = c_main_reg;
            cin_corr = c_corr_reg;
        end
    end

    assign is_last  = (idx == LAST_IDX);
    assign idx_inc  = idx + CNT_W'(1);
    assign beat_inc = cnt_reg + CNT_W'(1);
    assign to_emit  = dp_fire && is_last;

    // Framing faults on this beat; an upstream-flagged beat also marks the result.
    assign beat_err = in_fire && ((i_if.sop && (cnt_reg != '0)) ||
                                  (i_if.eop && !is_last) ||
                                  (is_last && !i_if.eop) ||
                                  i_if.err);

    // Main path: a+b (ADD) or a-b (SUB).
    ec_fpn_addsub_resp_chunk #(.W(W), .SUB(SUB)) u_main (
        .x    (op_a),
        .y    (op_b),
        .cin  (cin_main),
        .res  (r_main),
        .cout (cout_main)
    );

    // Correction path: main result -P (ADD) or +P (SUB).
    ec_fpn_addsub_resp_chunk #(.W(W), .SUB(!SUB)) u_corr (
        .x    (r_main),
        .y    (p_chunks[idx]),
        .cin  (cin_corr),
        .res  (r_corr),
        .cout (cout_corr)
    );

    // sel=1 returns the corrected buffer.
    // ADD: a+b >= P when it carried out of N bits or (a+b)-P did not borrow.
    // SUB: a-b went negative, so P must be added back.
    assign sel_next = SUB ? cout_main : (cout_main | ~cout_corr);

    // Beat 0 of the result: when DIV==1 it is still on the datapath, not in the buffer.
    always_comb begin
        if (sel_next) begin
            first_dat = (idx == '0) ? r_corr : buf_corr[0];
        end else begin
            first_dat = (idx == '0) ? r_main : buf_main[0];
        end
    end

    assign rd_dat = sel_reg ? buf_corr[beat_inc] : buf_main[beat_inc];

    // Result buffers: plain arrays, no reset.
    always_ff @(posedge i_clk) begin
        if (dp_fire) begin
            buf_main[idx] <= r_main;
            buf_corr[idx] <= r_corr;
        end
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg  <= ST_COLLECT;
            cnt_reg    <= '0;
            c_main_reg <= 1'b0;
            c_corr_reg <= 1'b0;
            err_reg    <= 1'b0;
            sel_reg    <= 1'b0;
            rdy_reg    <= 1'b0;
            ctl_reg    <= '0;
            o_val_reg  <= 1'b0;
            o_sop_reg  <= 1'b0;
            o_eop_reg  <= 1'b0;
            o_err_reg  <= 1'b0;
            o_dat_reg  <= '0;
            o_ctl_reg  <= '0;
        end else begin
            if (dp_fire) begin
                c_main_reg <= cout_main;
                c_corr_reg <= cout_corr;
                err_reg    <= err_reg | beat_err;
                if (in_fire && i_if.sop) begin
                    ctl_reg <= i_if.ctl;
                end
            end

            unique case (state_reg)
                ST_COLLECT: begin
                    rdy_reg <= 1'b1;
                    if (in_fire) begin
                        cnt_reg <= idx_inc;
                        if (!is_last && i_if.eop) begin
                            state_reg <= ST_FILL;
                            rdy_reg   <= 1'b0;
                        end
                    end
                end
                ST_FILL: begin
                    cnt_reg <= idx_inc;
                end
                ST_EMIT: begin
                    if (o_val_reg && o_if.rdy) begin
                        if (o_eop_reg) begin
                            state_reg <= ST_COLLECT;
                            rdy_reg   <= 1'b1;
                            cnt_reg   <= '0;
                            err_reg   <= 1'b0;
                            o_val_reg <= 1'b0;
                            o_sop_reg <= 1'b0;
                            o_eop_reg <= 1'b0;
                            o_err_reg <= 1'b0;
                        end else begin
                            cnt_reg   <= beat_inc;
                            o_dat_reg <= rd_dat;
                            o_sop_reg <= 1'b0;
                            o_eop_reg <= (beat_inc == LAST_IDX);
                            o_err_reg <= err_reg && (beat_inc == LAST_IDX);
                        end
                    end
                end
                default: begin
                    state_reg <= ST_COLLECT;
                end
            endcase

            // Last chunk processed: present result beat 0 on the next cycle.
            if (to_emit) begin
                state_reg <= ST_EMIT;
                cnt_reg   <= '0;
                rdy_reg   <= 1'b0;
                sel_reg   <= sel_next;
                o_val_reg <= 1'b1;
                o_sop_reg <= 1'b1;
                o_eop_reg <= (DIV == 1);
                o_err_reg <= (DIV == 1) && (err_reg || beat_err);
                o_dat_reg <= first_dat;
                o_ctl_reg <= (in_fire && i_if.sop) ? i_if.ctl : ctl_reg;
            end
        end
    end

    assign i_if.rdy = rdy_reg;
    assign o_if.val = o_val_reg;
    assign o_if.sop = o_sop_reg;
    assign o_if.eop = o_eop_reg;
    assign o_if.err = o_err_reg;
    assign o_if.dat = o_dat_reg;
    assign o_if.ctl = o_ctl_reg;

endmodule
